// File: rtl/iobus_timer_responder.sv
// IOBUS countdown timer: CTRL/LOAD/COUNT/STATUS window, prescaled tick, level interrupt on expiry.
// Reads are combinational (zero latency); writes land on the strobe edge; no backpressure, always ready.
module iobus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          PRESCALE  = 1,
    parameter int          CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    state_t           state, state_nxt;
    logic             auto_reload, int_en, expired;
    logic [CNT_W-1:0] load_val, count;
    logic [15:0]      pre;

    logic       hit, ctrl_wr, load_wr, status_wr;
    logic       tick, stop, start, run_tick, expire;
    logic [1:0] sel;
    logic       unused_bits;

    assign hit       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign sel       = IOBUS_ADDR[3:2];
    assign ctrl_wr   = IOBUS_WR && hit && (sel == 2'd0);
    assign load_wr   = IOBUS_WR && hit && (sel == 2'd1);
    assign status_wr = IOBUS_WR && hit && (sel == 2'd3);

    assign tick  = (state == RUN) && (pre == PRE_LAST);
    assign stop  = ctrl_wr && !IOBUS_OUT[0];
    assign start = ctrl_wr && IOBUS_OUT[0] && (state != RUN);
    // A stop write on a tick edge freezes COUNT; the tick is dropped.
    assign run_tick = tick && !stop;
    assign expire   = run_tick && (count == '0);

    assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

    always_comb begin
        state_nxt = state;
        if (stop)
            state_nxt = IDLE;
        else if (start)
            state_nxt = RUN;
        else if (expire && !auto_reload)
            state_nxt = DONE;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            auto_reload <= 1'b0;
            int_en      <= 1'b0;
            expired     <= 1'b0;
            load_val    <= '0;
            count       <= '0;
            pre         <= '0;
        end else begin
            state <= state_nxt;

            if (ctrl_wr) begin
                auto_reload <= IOBUS_OUT[1];
                int_en      <= IOBUS_OUT[2];
            end

            if (load_wr)
                load_val <= IOBUS_OUT[CNT_W-1:0];

            if (start)
                count <= load_val;
            else if (run_tick) begin
                if (count != '0)
                    count <= count - CNT_W'(1);
                else if (auto_reload)
                    count <= load_val;
            end

            // Prescaler only advances while staying in RUN; wraps on tick.
            if ((state == RUN) && (state_nxt == RUN) && !tick)
                pre <= pre + 16'd1;
            else
                pre <= '0;

            // Expiry beats a simultaneous write-1-to-clear.
            if (expire)
                expired <= 1'b1;
            else if (status_wr && IOBUS_OUT[0])
                expired <= 1'b0;
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        if (hit) begin
            case (sel)
                2'd0:    IOBUS_IN[2:0]       = {int_en, auto_reload, state == RUN};
                2'd1:    IOBUS_IN[CNT_W-1:0] = load_val;
                2'd2:    IOBUS_IN[CNT_W-1:0] = count;
                default: IOBUS_IN[0]         = expired;
            endcase
        end
    end

    assign INTR = expired && int_en;

endmodule

// File: doc/iobus_timer_responder.md
Name: iobus_timer_responder

Overview:
Memory-mapped countdown timer that sits on the CPU's IOBUS as a responder. It decodes IOBUS_ADDR, accepts 32-bit writes qualified by IOBUS_WR, and returns register contents on IOBUS_IN. It counts down a reloadable value using a prescaled tick and raises INTR toward the CPU's interrupt input on expiry.

Parameters:
BASE_ADDR, 32'h1100_0100, word-aligned base of the 16-byte register window
PRESCALE, 1, CLK cycles per count tick; legal range 1..65535
CNT_W, 32, width of LOAD/COUNT registers (≤32; upper read bits zero)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RESET_N  in  1  synchronous reset, active-low
IOBUS_ADDR  in  32  byte address from CPU MEM stage
IOBUS_OUT  in  32  write data from CPU
IOBUS_WR  in  1  write strobe, one cycle per store
IOBUS_IN  out  32  read data to CPU, combinational from IOBUS_ADDR
INTR  out  1  interrupt request, level, = STATUS.EXPIRED & CTRL.INT_EN

Behaviour:
- Register map (offset from BASE_ADDR; hit = ADDR[31:4]==BASE_ADDR[31:4]; ADDR[1:0] ignored):
  0x0 CTRL rw: bit0 EN, bit1 AUTO_RELOAD, bit2 INT_EN, other bits read 0
  0x4 LOAD rw: reload value, CNT_W bits
  0x8 COUNT ro: current count; writes ignored
  0xC STATUS: bit0 EXPIRED, sticky; write 1 clears, write 0 no effect
- Reads: IOBUS_IN = selected register when hit, else 32'h0; zero added latency, so the CPU memory stage samples it on the same edge as the address.
- Writes: take effect on the edge where IOBUS_WR=1 and hit; unmapped writes ignored. Full 32-bit writes only; no byte enables.
- Reset (RESET_N=0 at edge): CTRL=0, LOAD=0, COUNT=0, EXPIRED=0, prescaler=0, state IDLE. IOBUS_IN follows the reset registers; INTR=0. Reset wins over any simultaneous write or tick.
- Prescaler: counts 0..PRESCALE-1 while state RUN. tick=1 in a cycle where the prescaler equals PRESCALE-1, and the prescaler wraps to 0. The prescaler is held at 0 outside RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN: CTRL write with EN=1. Same edge: COUNT<=written-cycle LOAD (or the new LOAD if it is not written in that cycle), prescaler<=0.
  - RUN, tick, COUNT!=0: COUNT<=COUNT-1.
  - RUN, tick, COUNT==0: EXPIRED<=1. If AUTO_RELOAD: COUNT<=LOAD, stay RUN. Otherwise: go DONE, CTRL.EN<=0, COUNT stays 0.
  - Any state, CTRL write with EN=0 -> IDLE; COUNT held.
  - CTRL write with EN=1 while already RUN: only AUTO_RELOAD/INT_EN update; no restart.
- Period = (LOAD+1)*PRESCALE cycles. LOAD=0 expires every PRESCALE cycles.
- A LOAD write during RUN does not disturb COUNT; it takes effect at the next reload or restart.
- If an expiry event and a STATUS W1C hit the same edge, set wins: EXPIRED=1.
- INTR is combinational from registered state. It deasserts the cycle after a W1C or an INT_EN=0 write.

Test Plan:
- Reset: hold RESET_N=0 two cycles with IOBUS_WR=1 to CTRL -> all reads 0, INTR=0.
- One-shot, PRESCALE=1: write LOAD=3, then CTRL=3'b101. COUNT reads 3,2,1,0 on successive cycles; 4 edges after the CTRL write EXPIRED=1, INTR=1, CTRL reads 3'b100, state DONE, COUNT=0.
- Auto-reload, PRESCALE=4, LOAD=1: enable with CTRL=3'b011 -> EXPIRED sets 8 cycles after enable, COUNT reloads to 1. Clear STATUS on the exact expiry edge -> EXPIRED remains 1.
- W1C and mask: with EXPIRED=1, INT_EN=1, write STATUS=0 -> no change. Write STATUS=1 -> EXPIRED=0, INTR=0 next cycle. Set INT_EN=0 while EXPIRED=1 -> INTR=0 but STATUS reads 1.
- Mid-run LOAD write and stop: running with LOAD=10, write LOAD=2 at COUNT=7 -> COUNT continues 6,5,…. Write CTRL=0 at COUNT=4 -> COUNT frozen at 4, no expiry for 20 cycles.
- Decode: read BASE_ADDR+0x10 and 32'h1100_0000 -> IOBUS_IN=0; writes to them leave all registers unchanged; access at BASE_ADDR+0x6 aliases LOAD.
